rob_commit: RTL and testbench

ROB_COMMIT -- requirements
Module: rob_commit

---
 rtl/rv32i_types.sv | 25 ++
 rtl/rob_commit.sv | 114 +++++++++++
 tb/tb_rob_commit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: reorder-buffer entry layout and the commit
// bundle consumed by both the register file and the rename table.
package rv32i_types;

    localparam int ROB_IDX_WIDTH  = 5;
    localparam int XLEN           = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef struct packed {
        logic                      busy;
        logic                      done;
        logic                      mispredict;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [XLEN-1:0]           data;
    } rob_entry_t;

    typedef struct packed {
        logic                      regf_we;
        logic [REG_ADDR_WIDTH-1:0] commit_rd_addr;
        logic [XLEN-1:0]           commit_data;
        logic [ROB_IDX_WIDTH-1:0]  commit_rob_idx;
        logic                      flush;
    } commit_bundle_t;

endpackage

// File: rtl/rob_commit.sv
// In-order reorder buffer: allocates at dispatch, marks entries complete on
// writeback and retires one entry per cycle, flushing on a mispredicted commit.
module rob_commit #(
    parameter int ROB_IDX_WIDTH = rv32i_types::ROB_IDX_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     alloc_valid,
    input  logic [4:0]               alloc_rd_addr,
    output logic                     alloc_ready,
    output logic [ROB_IDX_WIDTH-1:0] alloc_rob_idx,
    input  logic                     wb_valid,
    input  logic [ROB_IDX_WIDTH-1:0] wb_rob_idx,
    input  logic [31:0]              wb_data,
    input  logic                     wb_mispredict,
    output logic                     regf_we,
    output logic [4:0]               commit_rd_addr,
    output logic [31:0]              commit_data,
    output logic [ROB_IDX_WIDTH-1:0] commit_rob_idx,
    output logic                     flush,
    output logic [ROB_IDX_WIDTH:0]   count
);
    import rv32i_types::*;

    localparam int                   DEPTH     = 1 << ROB_IDX_WIDTH;
    localparam logic [ROB_IDX_WIDTH:0] DEPTH_CNT = (ROB_IDX_WIDTH + 1)'(DEPTH);

    rob_entry_t                 entries [DEPTH];
    logic [ROB_IDX_WIDTH:0]     head_q;
    logic [ROB_IDX_WIDTH:0]     tail_q;
    commit_bundle_t             commit_q;

    logic [ROB_IDX_WIDTH-1:0]   head_idx;
    logic [ROB_IDX_WIDTH-1:0]   tail_idx;
    rob_entry_t                 head_entry;
    logic                       full;
    logic                       alloc_fire;
    logic                       commit_fire;
    logic                       commit_flush;
    logic                       wb_accept;

    assign head_idx = head_q[ROB_IDX_WIDTH-1:0];
    assign tail_idx = tail_q[ROB_IDX_WIDTH-1:0];

    // The extra wrap bit lets a plain subtraction distinguish full from empty.
    assign count = tail_q - head_q;
    assign full  = (count == DEPTH_CNT);

    assign alloc_ready   = !full && !commit_q.flush;
    assign alloc_rob_idx = tail_idx;
    assign alloc_fire    = alloc_valid && alloc_ready;

    assign head_entry   = entries[head_idx];
    assign commit_fire  = head_entry.busy && head_entry.done;
    assign commit_flush = commit_fire && head_entry.mispredict;
    assign wb_accept    = wb_valid && !commit_q.flush && entries[wb_rob_idx].busy;

    assign regf_we        = commit_q.regf_we;
    assign commit_rd_addr = commit_q.commit_rd_addr;
    assign commit_data    = commit_q.commit_data;
    assign commit_rob_idx = commit_q.commit_rob_idx;
    assign flush          = commit_q.flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            commit_q <= '0;
        end else begin
            commit_q.regf_we <= 1'b0;
            commit_q.flush   <= 1'b0;

            if (commit_fire) begin
                commit_q.regf_we        <= (head_entry.rd != 5'd0);
                commit_q.commit_rd_addr <= head_entry.rd;
                commit_q.commit_data    <= head_entry.data;
                commit_q.commit_rob_idx <= head_idx;
                commit_q.flush          <= head_entry.mispredict;
            end

            // A mispredicted commit squashes everything younger, including
            // whatever dispatch or writeback arrived in the same cycle.
            if (commit_flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    entries[i] <= '0;
                end
                head_q <= '0;
                tail_q <= '0;
            end else begin
                if (wb_accept) begin
                    entries[wb_rob_idx].done       <= 1'b1;
                    entries[wb_rob_idx].data       <= wb_data;
                    entries[wb_rob_idx].mispredict <= wb_mispredict;
                end
                if (commit_fire) begin
                    entries[head_idx] <= '0;
                    head_q            <= head_q + 1'b1;
                end
                if (alloc_fire) begin
                    entries[tail_idx].busy       <= 1'b1;
                    entries[tail_idx].done       <= 1'b0;
                    entries[tail_idx].mispredict <= 1'b0;
                    entries[tail_idx].rd         <= alloc_rd_addr;
                    entries[tail_idx].data       <= '0;
                    tail_q                       <= tail_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: expected commits are queued when the
// completing writeback is driven and matched as the commit outputs appear.
module tb_rob_commit;

    localparam int W = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           alloc_valid;
    logic [4:0]     alloc_rd_addr;
    logic           alloc_ready;
    logic [W-1:0]   alloc_rob_idx;
    logic           wb_valid;
    logic [W-1:0]   wb_rob_idx;
    logic [31:0]    wb_data;
    logic           wb_mispredict;
    logic           regf_we;
    logic [4:0]     commit_rd_addr;
    logic [31:0]    commit_data;
    logic [W-1:0]   commit_rob_idx;
    logic           flush;
    logic [W:0]     count;

    typedef struct packed {
        logic         we;
        logic [4:0]   rd;
        logic [31:0]  data;
        logic [W-1:0] idx;
        logic         fl;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    rob_commit #(.ROB_IDX_WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_valid    (alloc_valid),
        .alloc_rd_addr  (alloc_rd_addr),
        .alloc_ready    (alloc_ready),
        .alloc_rob_idx  (alloc_rob_idx),
        .wb_valid       (wb_valid),
        .wb_rob_idx     (wb_rob_idx),
        .wb_data        (wb_data),
        .wb_mispredict  (wb_mispredict),
        .regf_we        (regf_we),
        .commit_rd_addr (commit_rd_addr),
        .commit_data    (commit_data),
        .commit_rob_idx (commit_rob_idx),
        .flush          (flush),
        .count          (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and match any visible commit against the scoreboard.
    task automatic tick();
        exp_t got;
        exp_t want;
        @(posedge clk);
        #1;
        if (regf_we || flush) begin
            got = '{we: regf_we, rd: commit_rd_addr, data: commit_data, idx: commit_rob_idx, fl: flush};
            if (sb.size() == 0) begin
                checkOutput("unexpected_commit", 64'(got), 64'(0));
            end else begin
                want = sb.pop_front();
                checkOutput("commit", 64'(got), 64'(want));
            end
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic wv,
                                 input logic [W-1:0] widx, input logic [31:0] wdata, input logic wmis);
        alloc_valid   = av;
        alloc_rd_addr = ard;
        wb_valid      = wv;
        wb_rob_idx    = widx;
        wb_data       = wdata;
        wb_mispredict = wmis;
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 5'd0, 1'b0, '0, 32'd0, 1'b0);
        end
    endtask

    task automatic expectCommit(input logic we, input logic [4:0] rd, input logic [31:0] data,
                                input logic [W-1:0] idx, input logic fl);
        sb.push_back('{we: we, rd: rd, data: data, idx: idx, fl: fl});
    endtask

    initial begin
        rst = 1'b1;
        idle(2);
        checkOutput("rst_count", 64'(count), 64'd0);
        checkOutput("rst_outputs", 64'({regf_we, flush, commit_rd_addr, commit_data, commit_rob_idx}), 64'd0);
        rst = 1'b0;
        checkOutput("post_rst_ready", 64'(alloc_ready), 64'd1);
        checkOutput("post_rst_idx", 64'(alloc_rob_idx), 64'd0);

        // Three dispatches get consecutive indices.
        for (int i = 0; i < 3; i++) begin
            checkOutput("alloc_idx", 64'(alloc_rob_idx), 64'(i));
            applyStimulus(1'b1, 5'(5 + i), 1'b0, '0, 32'd0, 1'b0);
        end
        idle(1);
        checkOutput("count_3", 64'(count), 64'd3);

        // Out-of-order completion still retires in program order.
        expectCommit(1'b1, 5'd5, 32'h55, 5'd0, 1'b0);
        expectCommit(1'b1, 5'd6, 32'hAA, 5'd1, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b1, 5'd1, 32'hAA, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b1, 5'd0, 32'h55, 1'b0);
        checkOutput("sb_before_commit", 64'(sb.size()), 64'd2);
        idle(1);
        checkOutput("sb_after_first", 64'(sb.size()), 64'd1);
        idle(1);
        checkOutput("sb_after_second", 64'(sb.size()), 64'd0);
        checkOutput("count_pending", 64'(count), 64'd1);

        // rd=0 commits silently but still reports its index.
        expectCommit(1'b1, 5'd7, 32'h77, 5'd2, 1'b0);
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd2, 32'h77, 1'b0);
        idle(1);
        checkOutput("sb_idx2", 64'(sb.size()), 64'd0);
        applyStimulus(1'b0, 5'd0, 1'b1, 5'd3, 32'h1234, 1'b0);
        idle(1);
        checkOutput("rd0_we", 64'(regf_we), 64'd0);
        checkOutput("rd0_idx", 64'(commit_rob_idx), 64'd3);
        checkOutput("rd0_data", 64'(commit_data), 64'h1234);
        checkOutput("count_empty", 64'(count), 64'd0);

        // Fill all 32 slots starting at index 4 so the tail wraps through 0.
        for (int i = 0; i < 32; i++) begin
            checkOutput("fill_idx", 64'(alloc_rob_idx), 64'((4 + i) % 32));
            applyStimulus(1'b1, 5'((i % 31) + 1), 1'b0, '0, 32'd0, 1'b0);
        end
        checkOutput("full_count", 64'(count), 64'd32);
        checkOutput("full_ready", 64'(alloc_ready), 64'd0);
        checkOutput("full_idx", 64'(alloc_rob_idx), 64'd4);
        expectCommit(1'b1, 5'd1, 32'h400, 5'd4, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b1, 5'd4, 32'h400, 1'b0);
        checkOutput("full_ready_commit", 64'(alloc_ready), 64'd0);
        applyStimulus(1'b1, 5'd9, 1'b0, '0, 32'd0, 1'b0);
        checkOutput("no_alloc_when_full", 64'(count), 64'd31);
        checkOutput("sb_full_commit", 64'(sb.size()), 64'd0);
        checkOutput("ready_after_free", 64'(alloc_ready), 64'd1);
        checkOutput("idx_after_free", 64'(alloc_rob_idx), 64'd4);

        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checkOutput("midrst_count", 64'(count), 64'd0);
        checkOutput("midrst_we", 64'(regf_we), 64'd0);

        // Build entries 3,4,5 live with head at 3.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 5'(10 + i), 1'b0, '0, 32'd0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            expectCommit(1'b1, 5'(10 + i), 32'(32'h10 + i), 5'(i), 1'b0);
            applyStimulus(1'b0, 5'd0, 1'b1, 5'(i), 32'(32'h10 + i), 1'b0);
        end
        idle(1);
        checkOutput("live_345", 64'(count), 64'd3);

        expectCommit(1'b1, 5'd13, 32'h33, 5'd3, 1'b0);
        applyStimulus(1'b0, 5'd0, 1'b1, 5'd3, 32'h33, 1'b0);
        expectCommit(1'b1, 5'd14, 32'h44, 5'd4, 1'b1);
        applyStimulus(1'b0, 5'd0, 1'b1, 5'd4, 32'h44, 1'b1);
        checkOutput("trigger_ready", 64'(alloc_ready), 64'd1);
        checkOutput("trigger_idx", 64'(alloc_rob_idx), 64'd6);
        applyStimulus(1'b1, 5'd20, 1'b1, 5'd5, 32'h55, 1'b0);
        checkOutput("flush_pulse", 64'(flush), 64'd1);
        checkOutput("flush_count", 64'(count), 64'd0);
        checkOutput("flush_ready", 64'(alloc_ready), 64'd0);
        checkOutput("flush_idx", 64'(alloc_rob_idx), 64'd0);
        applyStimulus(1'b1, 5'd21, 1'b1, 5'd0, 32'h99, 1'b0);
        checkOutput("flush_clear", 64'(flush), 64'd0);
        checkOutput("post_flush_ready", 64'(alloc_ready), 64'd1);
        checkOutput("post_flush_idx", 64'(alloc_rob_idx), 64'd0);
        checkOutput("post_flush_count", 64'(count), 64'd0);
        idle(3);
        checkOutput("sb_after_flush", 64'(sb.size()), 64'd0);

        // Reset with 10 live entries and a committable head.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 5'(1 + i), (i == 9), 5'd0, 32'hCAFE, 1'b0);
        end
        checkOutput("ten_live", 64'(count), 64'd10);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checkOutput("rst10_count", 64'(count), 64'd0);
        checkOutput("rst10_we", 64'(regf_we), 64'd0);
        checkOutput("rst10_flush", 64'(flush), 64'd0);
        applyStimulus(1'b0, 5'd0, 1'b1, 5'd3, 32'hDEAD, 1'b0);
        idle(2);
        checkOutput("stale_wb_count", 64'(count), 64'd0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("realloc_idx", 64'(alloc_rob_idx), 64'(i));
            applyStimulus(1'b1, 5'(20 + i), 1'b0, '0, 32'd0, 1'b0);
        end
        idle(3);
        checkOutput("realloc_count", 64'(count), 64'd4);
        checkOutput("sb_final", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
